div_sequencer: RTL and testbench
================================

// Module: div_sequencer
// PURPOSE
// - Multi-cycle 32-bit DIV/DIVU engine and its sequencer, beside the EX stage ALU.
// - EX presents operands plus start; the block runs 32 restoring shift-subtract steps and holds the pipeline via stallreq_o.
// - Returns {remainder, quotient} for the HI/LO write path.
// - Flushes cleanly when the instruction is annulled by an exception.
// PARAMETERS
// - WIDTH  32  operand width; quotient and remainder are each WIDTH bits
// - CNT_W  6   step-counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
// - clk         in   1        clock; all state updates on the rising edge
// - rst_n       in   1        reset, asynchronous, active-low
// - start_i     in   1        EX requests a divide; held high until ready_o is seen
// - signed_i    in   1        1 = DIV (two's complement), 0 = DIVU
// - dividend_i  in   WIDTH    rs operand, sampled only on the accepting edge
// - divisor_i   in   WIDTH    rt operand, sampled only on the accepting edge
// - annul_i     in   1        flush; the exception is in progress
// - result_o    out  2*WIDTH  {remainder, quotient}; upper half goes to HI, lower half to LO
// - ready_o     out  1        result_o valid, asserted only in DONE
// - stallreq_o  out  1        pipeline stall request to the stall controller
// BEHAVIOUR
// - States: IDLE, ZERO, BUSY, DONE. Encodings are in defines.v.
// - Reset (rst_n=0, async): state=IDLE, cnt=0, result_o=0, ready_o=0, internal regs=0.
// - IDLE:
//   - start_i=1 and annul_i=0 latches operands and sign info.
//   - Divisor==0 -> ZERO; otherwise -> BUSY with cnt=0.
// - ZERO: one cycle, then -> DONE with result_o=64'h0.
// - BUSY: one step per cycle.
//   - Partial remainder is WIDTH+1 bits.
//   - Shift left by 1 and bring in the next dividend bit, MSB first.
//   - Trial-subtract |divisor|. If non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0.
//   - cnt increments each step. On the step with cnt==WIDTH-1 -> DONE.
// - DONE: ready_o=1 and result_o is valid.
//   - Stay in DONE while start_i=1.
//   - start_i=0 -> IDLE, ready_o=0. result_o keeps its last value.
// - Latency: ready_o rises WIDTH+1 edges after the accepting edge (33 for WIDTH=32).
//   - Divide by zero: 2 edges.
// - Signed mode:
//   - Operate on magnitudes (~x+1 when MSB=1).
//   - Negate the quotient when the operand signs differ.
//   - Remainder takes the sign of the dividend.
//   - -2^31 / -1 wraps: quotient=0x80000000, remainder=0. No trap.
// - stallreq_o = start_i & ~ready_o & ~annul_i. This is combinational, so the stall is already asserted in the accepting cycle.
// - annul_i=1 in any state: next state IDLE, ready_o=0, cnt=0, no result.
//   - A start_i in the same cycle is ignored.
// - Operand changes while in BUSY are ignored; only the latched copies are used.
// - start_i dropping during BUSY without annul_i aborts to IDLE. This is a protocol error and no result is produced.
// - Reset mid-operation aborts immediately; no partial result is visible.
// STRUCTURE
// - defines.v holds:
//   - state encodings DIV_IDLE/DIV_ZERO/DIV_BUSY/DIV_DONE
//   - the DIV/DIVU aluop codes, shared with ID and EX
// - One sub-module, div_step (combinational, one iteration):
//   - inputs: partial remainder, next dividend bit, |divisor|
//   - outputs: new remainder and quotient bit
// - The FSM, counter, sign fix-up and operand latches live in div_sequencer.
// TESTING
// - DIVU 100/7, start held high:
//   - stallreq_o=1 from the accepting cycle until DONE.
//   - ready_o rises 33 edges after acceptance with result_o={32'd2, 32'd14}.
// - DIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
//   - Also DIV 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
// - DIV 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0, ready_o after 33 edges.
// - DIVU 5/0 -> ZERO then DONE. ready_o 2 edges after acceptance, result_o=0.
// - annul_i pulsed at BUSY step 10:
//   - IDLE on the next edge; ready_o never rises.
//   - A new DIVU 9/3 accepted afterwards returns {0, 3}.
// - rst_n dropped mid-BUSY, asynchronously and not clock-aligned:
//   - state IDLE and all outputs 0 immediately.
//   - Operand changes during BUSY in a separate run do not alter the result.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider: sequencer state
// encodings, the DIV/DIVU aluop codes used by ID and EX, and default sizes.
package div_pkg;

    // Default operand width and step-counter width (2**CNT_W must exceed WIDTH).
    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    // Aluop codes decoded in ID and steered to this block from EX.
    localparam logic [7:0] ALUOP_DIV  = 8'b0001_1010;
    localparam logic [7:0] ALUOP_DIVU = 8'b0001_1011;

    // Sequencer states.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_BUSY = 2'b10,
        DIV_DONE = 2'b11
    } div_state_e;

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring shift-subtract iteration. The working partial remainder is
// WIDTH+1 bits wide. The stored remainder fits in WIDTH bits because it always
// stays below the divisor magnitude.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             quot_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Shift in the next dividend bit, trial-subtract, restore on a negative result.
    always_comb begin
        shifted    = {rem_i, bit_i};
        diff       = shifted - {1'b0, divisor_i};
        quot_bit_o = ~diff[WIDTH];
        // A restored value is below the divisor, so its top bit is always zero.
        rem_o      = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end

endmodule : div_step

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU engine that sits beside the EX-stage ALU. It latches
// the operands, runs WIDTH restoring steps on their magnitudes, applies the
// sign fix-up and holds {remainder, quotient} for the HI/LO write path.
module div_sequencer
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Holds the dividend magnitude. Its bits leave at the top while quotient
    // bits enter at the bottom, so after WIDTH steps it holds the quotient.
    logic [WIDTH-1:0]  dvd_q, dvd_d;
    logic [WIDTH-1:0]  dsr_q, dsr_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              neg_quot_q, neg_quot_d;
    logic              neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]  step_rem;
    logic              step_qbit;
    logic [WIDTH-1:0]  quot_raw;
    logic [WIDTH-1:0]  quot_fix;
    logic [WIDTH-1:0]  rem_fix;
    logic [WIDTH-1:0]  dividend_mag;
    logic [WIDTH-1:0]  divisor_mag;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[WIDTH-1]),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .quot_bit_o(step_qbit)
    );

    // Operand magnitudes and the final sign fix-up.
    // Unary minus is the same operation as ~x + 1.
    always_comb begin
        dividend_mag = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
        divisor_mag  = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;
        quot_raw     = {dvd_q[WIDTH-2:0], step_qbit};
        quot_fix     = neg_quot_q ? -quot_raw : quot_raw;
        rem_fix      = neg_rem_q  ? -step_rem : step_rem;
    end

    // Next-state and datapath updates. A flush overrides everything else.
    always_comb begin
        // NOTE: every signal gets its hold value first, so no path infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dsr_d      = dsr_q;
        rem_d      = rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;

        case (state_q)
            DIV_IDLE: begin
                if (start_i && !annul_i) begin
                    dvd_d      = dividend_mag;
                    dsr_d      = divisor_mag;
                    rem_d      = '0;
                    cnt_d      = '0;
                    neg_quot_d = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                    neg_rem_d  = signed_i & dividend_i[WIDTH-1];
                    state_d    = (divisor_i == '0) ? DIV_ZERO : DIV_BUSY;
                end
            end
            DIV_ZERO: begin
                result_d = '0;
                state_d  = DIV_DONE;
            end
            DIV_BUSY: begin
                if (!start_i) begin
                    // EX withdrew the request mid-divide. Drop the work silently.
                    state_d = DIV_IDLE;
                    cnt_d   = '0;
                end else begin
                    rem_d = step_rem;
                    dvd_d = quot_raw;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        result_d = {rem_fix, quot_fix};
                        state_d  = DIV_DONE;
                    end
                end
            end
            DIV_DONE: begin
                if (!start_i) begin
                    state_d = DIV_IDLE;
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        if (annul_i) begin
            state_d  = DIV_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            rem_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register see pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dsr_q      <= dsr_d;
            rem_q      <= rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = (state_q == DIV_DONE);
    assign stallreq_o = start_i & ~ready_o & ~annul_i;

endmodule : div_sequencer

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed vector table, multi-cycle
// corner sequences (flush, abort, async reset, operand churn) and random
// operands checked against an arithmetic reference model.
module tb_div_sequencer;
    import div_pkg::*;

    localparam int W = 32;

    logic           clk;
    logic           rst_n;
    logic           start_i;
    logic           signed_i;
    logic [W-1:0]   dividend_i;
    logic [W-1:0]   divisor_i;
    logic           annul_i;
    logic [2*W-1:0] result_o;
    logic           ready_o;
    logic           stallreq_o;

    int total = 0;
    int bad   = 0;

    div_sequencer #(
        .WIDTH(W),
        .CNT_W(6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .signed_i  (signed_i),
        .dividend_i(dividend_i),
        .divisor_i (divisor_i),
        .annul_i   (annul_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .stallreq_o(stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_r;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: plain integer division with truncation toward zero.
    task automatic ref_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb, lq, lr;
        if (b == 0) begin
            q = '0;
            r = '0;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[W-1:0];
            r  = lr[W-1:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Runs one divide starting just after a rising edge. The accepting edge counts as edge 1.
    task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] eq,
                           input logic [W-1:0] er, input bit scramble);
        int  edges;
        bit  got;
        bit  stall_ok;
        int  lat;
        lat        = (b == 0) ? 2 : W + 1;
        signed_i   = sgn;
        dividend_i = a;
        divisor_i  = b;
        annul_i    = 1'b0;
        start_i    = 1'b1;
        #1;
        check({tag, " stall_accept"}, {63'd0, stallreq_o}, 64'd1);
        edges    = 0;
        got      = 1'b0;
        stall_ok = 1'b1;
        while (edges < 60 && !got) begin
            @(posedge clk);
            #1;
            edges++;
            if (scramble) begin
                dividend_i = $urandom;
                divisor_i  = $urandom;
            end
            if (ready_o === 1'b1) got = 1'b1;
            else if (stallreq_o !== 1'b1) stall_ok = 1'b0;
        end
        check({tag, " ready_seen"}, {63'd0, got}, 64'd1);
        check({tag, " latency"}, 64'(edges), 64'(lat));
        check({tag, " stall_held"}, {63'd0, stall_ok}, 64'd1);
        check({tag, " result"}, result_o, {er, eq});
        check({tag, " stall_done"}, {63'd0, stallreq_o}, 64'd0);
        // Holding start keeps DONE and the result.
        @(posedge clk);
        #1;
        check({tag, " hold_ready"}, {63'd0, ready_o}, 64'd1);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " release_ready"}, {63'd0, ready_o}, 64'd0);
        check({tag, " release_keep"}, result_o, {er, eq});
    endtask

    // Watches for a stray ready_o over a window of edges.
    task automatic expect_quiet(input string tag, input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (ready_o !== 1'b0) seen = 1'b1;
        end
        check({tag, " no_ready"}, {63'd0, seen}, 64'd0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [W-1:0] rq, rr, ra, rb;
        logic         rs;

        vecs.push_back('{ALUOP_DIVU, 32'd100,       32'd7,         32'd14,        32'd2});
        vecs.push_back('{ALUOP_DIV,  32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF});
        vecs.push_back('{ALUOP_DIV,  32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'h00000001});
        vecs.push_back('{ALUOP_DIV,  32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'h0});
        vecs.push_back('{ALUOP_DIVU, 32'd5,         32'd0,         32'h0,         32'h0});
        vecs.push_back('{ALUOP_DIVU, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'h0});
        vecs.push_back('{ALUOP_DIVU, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         32'h0});
        vecs.push_back('{ALUOP_DIVU, 32'd3,         32'd10,        32'd0,         32'd3});
        vecs.push_back('{ALUOP_DIV,  32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE});
        vecs.push_back('{ALUOP_DIVU, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000});
        vecs.push_back('{ALUOP_DIV,  32'hFFFFFFFF,  32'd0,         32'h0,         32'h0});

        rst_n      = 1'b0;
        start_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        annul_i    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", {63'd0, ready_o}, 64'd0);
        check("reset result", result_o, 64'd0);
        check("reset stall", {63'd0, stallreq_o}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table.
        foreach (vecs[i]) begin
            run_div($sformatf("vec%0d", i), vecs[i].op == ALUOP_DIV,
                    vecs[i].a, vecs[i].b, vecs[i].exp_q, vecs[i].exp_r, 1'b0);
        end

        // annul together with start in IDLE must not be accepted.
        start_i    = 1'b1;
        annul_i    = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd50;
        divisor_i  = 32'd5;
        #1;
        check("annul_idle stall", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk);
        #1;
        run_div("after_annul_idle", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);

        // annul pulsed at BUSY step 10, then a fresh divide.
        signed_i   = 1'b0;
        dividend_i = 32'd1000;
        divisor_i  = 32'd3;
        start_i    = 1'b1;
        repeat (11) begin
            @(posedge clk);
            #1;
        end
        annul_i = 1'b1;
        #1;
        check("annul busy stall", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        expect_quiet("annul", 40);
        run_div("after_annul", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        // start dropped mid-BUSY aborts with no result.
        signed_i   = 1'b1;
        dividend_i = 32'd77;
        divisor_i  = 32'd4;
        start_i    = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        expect_quiet("abort", 40);
        check("abort keep", result_o, {32'd0, 32'd3});

        // Operand churn during BUSY must not affect the result.
        run_div("churn", 1'b0, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b1);

        // Asynchronous reset mid-BUSY, off the clock edge.
        signed_i   = 1'b0;
        dividend_i = 32'hDEADBEEF;
        divisor_i  = 32'd13;
        start_i    = 1'b1;
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n   = 1'b0;
        start_i = 1'b0;
        #1;
        check("async_rst ready", {63'd0, ready_o}, 64'd0);
        check("async_rst result", result_o, 64'd0);
        check("async_rst stall", {63'd0, stallreq_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_quiet("async_rst", 40);

        // Random operands against the reference model.
        for (int n = 0; n < 40; n++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(0, 15));
                1:       rb = $urandom >> $urandom_range(0, 31);
                2:       rb = -32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            if (n % 10 == 0) rb = '0;
            ref_div(rs, ra, rb, rq, rr);
            run_div($sformatf("rnd%0d", n), rs, ra, rb, rq, rr, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_div_sequencer
